// File: rtl/serial_tc_pkg.sv
// Shared definitions for the bit-serial two's complement datapath:
// negation state encoding, default width and the most-negative-value detector.
package serial_tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    INV  = 2'd2
  } tc_state_e;

  localparam int unsigned DEF_W = 8;
  localparam int unsigned MAX_W = 64;

  // True when the low w bits of word are 1 followed by w-1 zeros (-2^(w-1)).
  function automatic logic is_ovf_word(input logic [MAX_W-1:0] word, input int unsigned w);
    logic ok;
    ok = 1'b1;
    for (int unsigned k = 0; k < MAX_W; k++) begin
      if (k + 1 < w) begin
        ok = ok & ~word[k];
      end else if (k + 1 == w) begin
        ok = ok & word[k];
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/serial_negate_cell.sv
// Bit-serial negation core: tracks whether a 1 has been seen in the current
// frame and passes or inverts each accepted bit accordingly.
module serial_negate_cell
  import serial_tc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic accept,
  input  logic frame_last,
  input  logic bit_in,
  output logic bit_out
);

  tc_state_e state_q, state_d;
  logic      inv_s;

  // A restarting frame is treated as SEEK even if the previous one was in INV.
  always_comb begin
    inv_s   = (state_q == INV) && !frame_start;
    bit_out = inv_s ? ~bit_in : bit_in;
    state_d = state_q;
    if (!accept) begin
      state_d = state_q;
    end else if (frame_last) begin
      state_d = IDLE;
    end else if (inv_s || bit_in) begin
      state_d = INV;
    end else begin
      state_d = SEEK;
    end
  end

  // Negation state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/serial_twos_deserializer.sv
// Receive-side deserializer: negates an LSB-first framed serial stream and
// assembles the result into a parallel word with a one-cycle valid pulse.
module serial_twos_deserializer
  import serial_tc_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic         i,
  input  logic         start,
  output logic         y,
  output logic         busy,
  output logic [W-1:0] data_out,
  output logic         valid,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-2:0]  sh_q, sh_d;
  logic [W-1:0]  data_q, data_d;
  logic          y_q, y_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic          accept_s;
  logic          last_s;
  logic          neg_s;
  logic [W-1:0]  word_s;

  assign accept_s = start | busy_q;
  assign last_s   = busy_q & ~start & (cnt_q == LAST_CNT);
  assign word_s   = {neg_s, sh_q};

  serial_negate_cell u_cell (
    .clk         (t_clk),
    .rst_n       (r),
    .frame_start (start),
    .accept      (accept_s),
    .frame_last  (last_s),
    .bit_in      (i),
    .bit_out     (neg_s)
  );

  // Framing: start always opens a new frame; the W-th accepted bit closes it.
  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    y_d     = 1'b0;
    busy_d  = busy_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    if (start) begin
      cnt_d  = ONE_CNT;
      sh_d   = word_s[W-1:1];
      y_d    = neg_s;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d = word_s[W-1:1];
      y_d  = neg_s;
      if (last_s) begin
        cnt_d   = {CW{1'b0}};
        busy_d  = 1'b0;
        data_d  = word_s;
        valid_d = 1'b1;
        ovf_d   = is_ovf_word(MAX_W'(word_s), W);
      end else begin
        cnt_d = cnt_q + ONE_CNT;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      cnt_q   <= {CW{1'b0}};
      sh_q    <= {(W-1){1'b0}};
      data_q  <= {W{1'b0}};
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign y        = y_q;
  assign busy     = busy_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_serial_twos_deserializer.sv
// Self-checking bench: per-cycle comparison against an arithmetic model of
// serial negation, plus hand-computed expectations for directed frames.
module tb_serial_twos_deserializer;

  localparam int W = 8;

  logic       t_clk = 1'b0;
  logic       r, i, start;
  logic       y, busy, valid, ovf;
  logic [7:0] data_out;

  always #5 t_clk = ~t_clk;

  serial_twos_deserializer #(.W(W)) dut (
    .t_clk    (t_clk),
    .r        (r),
    .i        (i),
    .start    (start),
    .y        (y),
    .busy     (busy),
    .data_out (data_out),
    .valid    (valid),
    .ovf      (ovf)
  );

  int checks = 0;
  int failures = 0;

  logic       exp_y = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0, exp_ovf = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       p_y = 1'b0, p_busy = 1'b0, p_valid = 1'b0, p_ovf = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       chk_en = 1'b0;

  // model: operand bits received so far and position of the next bit
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_x = 32'h0;

  int cyc = 0, vcount = 0, last_vcyc = 0, prev_vcyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge t_clk) begin
    if (chk_en) begin
      check("y", {31'd0, y}, {31'd0, exp_y});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("valid", {31'd0, valid}, {31'd0, exp_valid});
      check("data_out", {24'd0, data_out}, {24'd0, exp_data});
      check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    end
  end

  always @(negedge t_clk) begin
    cyc++;
    if (valid === 1'b1) begin
      vcount++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
  end

  // One clock: drive inputs, predict outputs after the edge, advance.
  task automatic cycle(input logic s, input logic b);
    logic [31:0] neg;
    int k;
    logic acc;
    start = s;
    i = b;
    acc = 1'b0;
    k = 0;
    p_valid = 1'b0;
    p_y = 1'b0;
    if (!r) begin
      m_busy = 1'b0;
      p_data = 8'h00;
      p_ovf = 1'b0;
    end else if (s) begin
      m_x = {31'd0, b};
      acc = 1'b1;
    end else if (m_busy) begin
      k = m_cnt;
      m_x = m_x | ({31'd0, b} << k);
      acc = 1'b1;
    end
    if (acc) begin
      neg = 32'd0 - m_x;
      p_y = neg[k];
      if (k == W - 1) begin
        p_valid = 1'b1;
        p_data = neg[7:0];
        p_ovf = (m_x == 32'h80);
        m_busy = 1'b0;
      end else begin
        m_busy = 1'b1;
        m_cnt = k + 1;
      end
    end
    p_busy = m_busy;
    @(posedge t_clk);
    exp_y = p_y; exp_busy = p_busy; exp_valid = p_valid;
    exp_data = p_data; exp_ovf = p_ovf;
    #1;
  endtask

  task automatic send(input logic [7:0] x);
    for (int k = 0; k < 8; k++) cycle(k == 0, x[k]);
  endtask

  logic [7:0] ycap;
  logic [7:0] fa;
  int v0;

  initial begin
    r = 1'b0; start = 1'b0; i = 1'b0;
    repeat (2) @(posedge t_clk);
    #1;
    chk_en = 1'b1;
    cycle(1'b0, 1'b0);
    r = 1'b1;
    check("rst_data", {24'd0, data_out}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);

    // 0x05 -> y stream 1,1,0,1,1,1,1,1 and word 0xFB
    v0 = vcount;
    fa = 8'h05;
    for (int k = 0; k < 8; k++) begin
      cycle(k == 0, fa[k]);
      ycap[k] = y;
    end
    cycle(1'b0, 1'b0);
    check("y_stream_05", {24'd0, ycap}, 32'hFB);
    check("data_05", {24'd0, data_out}, 32'hFB);
    check("ovf_05", {31'd0, ovf}, 32'h0);
    check("valid_cnt_05", vcount - v0, 32'd1);

    send(8'h00); cycle(1'b0, 1'b0);
    check("data_00", {24'd0, data_out}, 32'h00);
    check("ovf_00", {31'd0, ovf}, 32'h0);
    send(8'hFF); cycle(1'b0, 1'b1);
    check("data_FF", {24'd0, data_out}, 32'h01);
    send(8'h80); cycle(1'b0, 1'b0);
    check("data_80", {24'd0, data_out}, 32'h80);
    check("ovf_80", {31'd0, ovf}, 32'h1);

    // back-to-back frames
    v0 = vcount;
    send(8'h01);
    check("b2b_first", {24'd0, data_out}, 32'hFF);
    send(8'h7F);
    cycle(1'b0, 1'b0);
    check("b2b_second", {24'd0, data_out}, 32'h81);
    check("b2b_valids", vcount - v0, 32'd2);
    check("b2b_spacing", last_vcyc - prev_vcyc, 32'd8);

    // restart at bit 4 aborts the first frame
    v0 = vcount;
    fa = 8'h12;
    for (int k = 0; k < 4; k++) cycle(k == 0, fa[k]);
    send(8'h03);
    cycle(1'b0, 1'b0);
    check("abort_valids", vcount - v0, 32'd1);
    check("abort_data", {24'd0, data_out}, 32'hFD);

    // reset during bit 5
    v0 = vcount;
    for (int k = 0; k < 5; k++) cycle(k == 0, fa[k]);
    r = 1'b0;
    m_busy = 1'b0;
    exp_y = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; exp_data = 8'h00; exp_ovf = 1'b0;
    p_data = 8'h00; p_ovf = 1'b0;
    cycle(1'b0, fa[5]);
    cycle(1'b0, 1'b0);
    r = 1'b1;
    repeat (10) cycle(1'b0, 1'($urandom));
    check("rst_mid_valids", vcount - v0, 32'd0);
    check("rst_mid_data", {24'd0, data_out}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'h0);
    send(8'h05); cycle(1'b0, 1'b0);
    check("post_rst_data", {24'd0, data_out}, 32'hFB);

    // random regression
    v0 = vcount;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'($urandom));
      send(8'($urandom));
    end
    cycle(1'b0, 1'b0);
    check("rand_valids", vcount - v0, 32'd1000);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
